// File: rtl/matrix_mul_stream.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_mul_stream
//  Description : Streaming DIM x DIM matrix multiplier, C = A x B. A and B
//                are loaded one row per beat, DIM parallel MAC lanes build one
//                row of C every DIM cycles, and each C row is returned over a
//                valid/ready port.
//                Optional macro MATRIX_MUL_STREAM_SAT_EN: when defined, the
//                result elements saturate to the OUT_W range instead of
//                wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_mul_stream #(
    parameter int DIM    = 8,
    parameter int DATA_W = 16,
    parameter int SIGNED = 0,
    parameter int OUT_W  = 2*DATA_W + $clog2(DIM)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DIM*DATA_W-1:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DIM*OUT_W-1:0]    out_data,
    output logic [$clog2(DIM)-1:0]  out_row,
    output logic                    busy,
    output logic                    done
);

    localparam int IDX_W  = $clog2(DIM);
    localparam int PROD_W = 2*DATA_W;
    localparam int ACC_W  = 2*DATA_W + $clog2(DIM);
    localparam int EXT_W  = ACC_W - PROD_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM-1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_MAC    = 3'd3,
        S_OUT    = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_row_cnt;
    logic [IDX_W-1:0]   r_i;
    logic [IDX_W-1:0]   r_k;
    logic               r_done;
    logic [DATA_W-1:0]  a_mem [DIM][DIM];
    logic [DATA_W-1:0]  b_mem [DIM][DIM];
    logic [ACC_W-1:0]   r_acc [DIM];

    logic               w_beat;
    logic               w_last_beat;
    logic               w_last_k;
    logic               w_last_row;
    logic               w_acc_clr;
    logic [DATA_W-1:0]  w_a_elem;
    logic [PROD_W-1:0]  w_a_ext;

    assign in_ready    = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
    assign out_valid   = (r_state == S_OUT);
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign out_row     = r_i;

    assign w_beat      = in_valid & in_ready;
    assign w_last_beat = w_beat & (r_row_cnt == LAST_IDX);
    assign w_last_k    = (r_k == LAST_IDX);
    assign w_last_row  = (r_i == LAST_IDX);
    // Accumulators restart when MAC is entered, either from the load phase or
    // after a result row has been handed off.
    assign w_acc_clr   = ((r_state == S_LOAD_B) & w_last_beat) |
                         ((r_state == S_OUT) & out_ready);

    // A[i][k] is common to every lane in a given MAC cycle.
    assign w_a_elem    = a_mem[r_i][r_k];

    generate
        if (SIGNED != 0) begin : g_a_signed
            assign w_a_ext = {{DATA_W{w_a_elem[DATA_W-1]}}, w_a_elem};
        end else begin : g_a_unsigned
            assign w_a_ext = {{DATA_W{1'b0}}, w_a_elem};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; clear overrides everything, including start.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start)       w_state_nxt = S_LOAD_A;
            S_LOAD_A: if (w_last_beat) w_state_nxt = S_LOAD_B;
            S_LOAD_B: if (w_last_beat) w_state_nxt = S_MAC;
            S_MAC:    if (w_last_k)    w_state_nxt = S_OUT;
            S_OUT: begin
                if (out_ready) begin
                    w_state_nxt = w_last_row ? S_IDLE : S_MAC;
                end
            end
            default:                   w_state_nxt = S_IDLE;
        endcase
        if (clear) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Row/column counters and the done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_row_cnt <= '0;
            r_i       <= '0;
            r_k       <= '0;
            r_done    <= 1'b0;
        end else if (clear) begin
            r_row_cnt <= '0;
            r_i       <= '0;
            r_k       <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_row_cnt <= '0;
                    r_i       <= '0;
                    r_k       <= '0;
                end
                S_LOAD_A, S_LOAD_B: begin
                    if (w_beat) begin
                        r_row_cnt <= w_last_beat ? '0 : r_row_cnt + 1'b1;
                    end
                    if (w_last_beat) begin
                        r_i <= '0;
                        r_k <= '0;
                    end
                end
                S_MAC: begin
                    r_k <= w_last_k ? '0 : r_k + 1'b1;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_k <= '0;
                        if (w_last_row) begin
                            r_i    <= '0;
                            r_done <= 1'b1;
                        end else begin
                            r_i <= r_i + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand storage; contents survive clear and are always fully reloaded.
    always_ff @(posedge clk) begin
        if (!clear && w_beat) begin
            for (int c = 0; c < DIM; c++) begin
                if (r_state == S_LOAD_A) begin
                    a_mem[r_row_cnt][c] <= in_data[c*DATA_W +: DATA_W];
                end else begin
                    b_mem[r_row_cnt][c] <= in_data[c*DATA_W +: DATA_W];
                end
            end
        end
    end

    generate
        for (genvar j = 0; j < DIM; j++) begin : g_lane
            logic [DATA_W-1:0] w_b_elem;
            logic [PROD_W-1:0] w_b_ext;
            logic [PROD_W-1:0] w_prod;
            logic [ACC_W-1:0]  w_prod_ext;
            logic [OUT_W-1:0]  w_fmt;

            assign w_b_elem = b_mem[r_k][j];

            // The low PROD_W bits of the product are the same for signed and
            // unsigned operands once they are extended to PROD_W.
            if (SIGNED != 0) begin : g_signed
                assign w_b_ext    = {{DATA_W{w_b_elem[DATA_W-1]}}, w_b_elem};
                assign w_prod     = w_a_ext * w_b_ext;
                assign w_prod_ext = {{EXT_W{w_prod[PROD_W-1]}}, w_prod};
            end else begin : g_unsigned
                assign w_b_ext    = {{DATA_W{1'b0}}, w_b_elem};
                assign w_prod     = w_a_ext * w_b_ext;
                assign w_prod_ext = {{EXT_W{1'b0}}, w_prod};
            end

            // Lane accumulator for C[i][j].
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_acc[j] <= '0;
                end else if (clear || w_acc_clr) begin
                    r_acc[j] <= '0;
                end else if (r_state == S_MAC) begin
                    r_acc[j] <= r_acc[j] + w_prod_ext;
                end
            end

            if (OUT_W == ACC_W) begin : g_full
                assign w_fmt = r_acc[j];
            end else begin : g_narrow
`ifdef MATRIX_MUL_STREAM_SAT_EN
                if (SIGNED != 0) begin : g_sat_signed
                    logic [ACC_W-OUT_W:0] w_top;
                    assign w_top = r_acc[j][ACC_W-1:OUT_W-1];
                    // Saturate when the discarded bits are not a sign extension.
                    always_comb begin
                        w_fmt = r_acc[j][OUT_W-1:0];
                        if (!((&w_top) || !(|w_top))) begin
                            w_fmt = r_acc[j][ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                                      : {1'b0, {(OUT_W-1){1'b1}}};
                        end
                    end
                end else begin : g_sat_unsigned
                    assign w_fmt = (|r_acc[j][ACC_W-1:OUT_W]) ? {OUT_W{1'b1}}
                                                              : r_acc[j][OUT_W-1:0];
                end
`else
                logic w_unused_hi;
                assign w_unused_hi = ^r_acc[j][ACC_W-1:OUT_W];
                assign w_fmt       = r_acc[j][OUT_W-1:0];
`endif
            end

            assign out_data[j*OUT_W +: OUT_W] = w_fmt;
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/matrix_mul_stream.md
# matrix_mul_stream

Parametrised streaming square-matrix multiplier, C = A×B, for DIM×DIM matrices of DATA_W-bit elements. Operands are loaded one row per beat over a valid/ready input port. DIM parallel MAC lanes then compute one row of C every DIM cycles. Each result row is returned over a valid/ready output port. The block sits beside the sigma core as a memory-mapped accelerator and supersedes the fixed 8×8, 32-bit, whole-array-port multiplier.

## Interface
- DIM, 8: matrix dimension, 2..16.
- DATA_W, 16: operand element width.
- SIGNED, 0: 1 means two's-complement operands and products; 0 means unsigned.
- OUT_W, 2*DATA_W+$clog2(DIM): result element width, ≤ ACC_W.
- ACC_W (localparam) = 2*DATA_W+$clog2(DIM): accumulator width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort, returns the block to IDLE.
- start  in  1  one-cycle pulse; begins a job when in IDLE.
- in_valid  in  1  input row valid.
- in_ready  out  1  block accepts an input row.
- in_data  in  DIM*DATA_W  one matrix row; element j sits at bits [j*DATA_W +: DATA_W].
- out_valid  out  1  result row valid.
- out_ready  in  1  consumer accepts the result row.
- out_data  out  DIM*OUT_W  one C row; element j sits at bits [j*OUT_W +: OUT_W].
- out_row  out  $clog2(DIM)  index of the row currently on out_data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last C row is accepted.

## Operation
- States: IDLE, LOAD_A, LOAD_B, MAC, OUT.
- IDLE → LOAD_A on start. start in any other state is ignored.
- LOAD_A: in_ready=1. Each accepted beat (in_valid&in_ready) writes A row r, where r counts 0..DIM-1. After row DIM-1 is accepted, go to LOAD_B with r=0.
- LOAD_B: same as LOAD_A, filling B rows 0..DIM-1. After row DIM-1, go to MAC with i=0, k=0, all acc=0.
- MAC: every cycle, acc[j] += A[i][k]*B[k][j] for all j in parallel, then k++. After k=DIM-1, go to OUT.
- OUT: out_valid=1; out_data=fmt(acc); out_row=i. Data is held stable until out_ready.
  - On acceptance with i<DIM-1: i++, k=0, acc cleared, go to MAC.
  - On acceptance with i=DIM-1: go to IDLE and pulse done.
- in_valid outside the LOAD states is ignored; in_ready=0 there.
- Arithmetic:
  - Products are 2*DATA_W bits, sign- or zero-extended per SIGNED into ACC_W.
  - The accumulator cannot overflow at ACC_W.
  - fmt() reduces ACC_W to OUT_W (see Configuration). When OUT_W=ACC_W, fmt is the identity.
- clear, in any state: go to IDLE; out_valid, busy and done go to 0; counters and acc go to 0. No done pulse is issued. The A and B arrays keep their contents but are never read without a full reload.
- clear and start in the same cycle: clear wins.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, out_row=0, busy=0, done=0; state=IDLE.
- start sampled at cycle t: LOAD_A from t+1, so in_ready=1 at t+1.
- Last B beat accepted at cycle u: MAC runs cycles u+1..u+DIM; out_valid=1 from u+DIM+1.
- Row accepted at cycle v with more rows to go: MAC runs v+1..v+DIM; next out_valid from v+DIM+1.
- Minimum job latency with no stalls: 1 + 2*DIM + DIM*(DIM+1) cycles from start to the done pulse.
- done is high for exactly the one cycle after the final out handshake; busy=0 in that same cycle.
- A back-to-back start is accepted in the done cycle.
- reset_n asserted mid-job: all outputs take their reset values immediately (asynchronously); the job is lost.

## Configuration
- MATRIX_MUL_STREAM_SAT_EN defined: fmt() saturates to the OUT_W range.
  - Unsigned range: 0..2^OUT_W-1.
  - Signed range: -2^(OUT_W-1)..2^(OUT_W-1)-1.
- MATRIX_MUL_STREAM_SAT_EN undefined: fmt() keeps acc[OUT_W-1:0] (wrap-around truncation).
- The macro has no effect when OUT_W=ACC_W.

## Test plan
All scenarios use DIM=4, DATA_W=8 unless stated.
- Identity: A=I, B[r][c]=4r+c, SIGNED=0, no stalls. Required: C rows equal B rows, out_row=0..3, done at cycle 1+8+20 after start.
- Backpressure: random in_valid and out_ready at 50% duty, random unsigned data. Required: out_data matches the reference model, stays stable while out_valid&!out_ready, and the row order is 0..3.
- Signed: SIGNED=1, A all -128, B all 127. Required: every C element = -65024 at OUT_W=18.
- Saturation: SIGNED=0, OUT_W=16, A and B all 255, each element 260100.
  - With MATRIX_MUL_STREAM_SAT_EN: every element = 65535.
  - Without it: every element = 63492.
- Abort: assert clear during MAC of row 2. Required: next cycle busy=0, out_valid=0, no done pulse; a following full job produces correct results.
- Reset: pull reset_n low during LOAD_B. Required: all outputs at reset values with no clock edge; start after release runs a correct job.
